// File: rtl/sram_dp_param_clr_if.sv
// Bus bundle for the dual-port clearable SRAM: port A read/write, port B read-only,
// plus the clear-sweep busy flag.
interface sram_dp_param_clr_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a;
  logic          wr_a_n;
  logic          rd_a_n;
  logic [DW-1:0] dout_a;
  logic          rvalid_a;
  logic [AW-1:0] addr_b;
  logic          rd_b_n;
  logic [DW-1:0] dout_b;
  logic          rvalid_b;
  logic          busy;

  modport master (
    output addr_a, din_a, wr_a_n, rd_a_n, addr_b, rd_b_n,
    input  dout_a, rvalid_a, dout_b, rvalid_b, busy
  );

  modport slave (
    input  addr_a, din_a, wr_a_n, rd_a_n, addr_b, rd_b_n,
    output dout_a, rvalid_a, dout_b, rvalid_b, busy
  );
endinterface

// File: rtl/sram_dp_param_clr.sv
// Parametrised synchronous dual-port SRAM model. Port A reads/writes (CPU side),
// port B is read-only (video side). Optional post-reset sweep writes CLEAR_VAL
// to every word so the array starts from a known state.
//
// state    | meaning
// ST_CLEAR | sweeping one word per clock with CLEAR_VAL; port A ignored
// ST_IDLE  | normal operation on both ports
module sram_dp_param_clr #(
  parameter int unsigned   AW         = 12,
  parameter int unsigned   DW         = 8,
  parameter int unsigned   RD_LATENCY = 1,
  parameter int unsigned   WRITE_MODE = 0,
  parameter int unsigned   CLEAR_EN   = 1,
  parameter logic [DW-1:0] CLEAR_VAL  = '0
) (
  input logic                i_MCLK,
  input logic                i_RST,
  sram_dp_param_clr_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [DW-1:0] mem [0:(2**AW)-1];

  logic          idle;
  logic          rd_a_req, rd_b_req;
  logic [DW-1:0] rd_a_data, rd_b_data;

  logic          a1_vld_q, b1_vld_q;
  logic [DW-1:0] a1_data_q, b1_data_q;

  assign idle     = (state_q == ST_IDLE);
  assign bus.busy = (state_q == ST_CLEAR);

  // State register and sweep address; reset restarts the sweep at word 0
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      if (CLEAR_EN != 0) state_q <= ST_CLEAR;
      else               state_q <= ST_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state: leave CLEAR on the edge that writes the last address
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) state_d = ST_IDLE;
    end
  end

  // RAM array write: sweep owns the write port while clearing; contents are never reset
  always_ff @(posedge i_MCLK) begin
    if (!i_RST) begin
      if (!idle)             mem[clr_addr_q]  <= CLEAR_VAL;
      else if (!bus.wr_a_n)  mem[bus.addr_a] <= bus.din_a;
    end
  end

  // Port A has a single address, so a simultaneous read+write is always same-address
  // and WRITE_MODE alone picks old or new data. Port B always sees old data.
  always_comb begin
    rd_a_req  = idle && !bus.rd_a_n;
    rd_b_req  = !bus.rd_b_n;
    rd_a_data = mem[bus.addr_a];
    if ((WRITE_MODE != 0) && !bus.wr_a_n) rd_a_data = bus.din_a;
    rd_b_data = mem[bus.addr_b];
  end

  // First read stage: data register only loads on an accepted read, otherwise holds
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      a1_vld_q  <= 1'b0;
      b1_vld_q  <= 1'b0;
      a1_data_q <= '0;
      b1_data_q <= '0;
    end else begin
      a1_vld_q <= rd_a_req;
      b1_vld_q <= rd_b_req;
      if (rd_a_req) a1_data_q <= rd_a_data;
      if (rd_b_req) b1_data_q <= rd_b_data;
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign bus.dout_a   = a1_data_q;
    assign bus.rvalid_a = a1_vld_q;
    assign bus.dout_b   = b1_data_q;
    assign bus.rvalid_b = b1_vld_q;
  end else if (RD_LATENCY == 2) begin : g_lat2
    logic          a2_vld_q, b2_vld_q;
    logic [DW-1:0] a2_data_q, b2_data_q;

    // Output register stage; holds last result when nothing completes
    always_ff @(posedge i_MCLK) begin
      if (i_RST) begin
        a2_vld_q  <= 1'b0;
        b2_vld_q  <= 1'b0;
        a2_data_q <= '0;
        b2_data_q <= '0;
      end else begin
        a2_vld_q <= a1_vld_q;
        b2_vld_q <= b1_vld_q;
        if (a1_vld_q) a2_data_q <= a1_data_q;
        if (b1_vld_q) b2_data_q <= b1_data_q;
      end
    end

    assign bus.dout_a   = a2_data_q;
    assign bus.rvalid_a = a2_vld_q;
    assign bus.dout_b   = b2_data_q;
    assign bus.rvalid_b = b2_vld_q;
  end else begin : g_bad_latency
    $error("sram_dp_param_clr: RD_LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_sram_dp_param_clr.sv
// Directed bench for sram_dp_param_clr: three instances cover the default config
// (read-first, 4K sweep), write-first without sweep, and 2-cycle latency with DW=16.
module tb_sram_dp_param_clr;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n;
  logic [15:0] v2 [4];

  always #5 clk = ~clk;

  sram_dp_param_clr_if #(.AW(12), .DW(8))  if0 ();
  sram_dp_param_clr_if #(.AW(8),  .DW(8))  if1 ();
  sram_dp_param_clr_if #(.AW(8),  .DW(16)) if2 ();

  sram_dp_param_clr #(.AW(12), .DW(8), .RD_LATENCY(1), .WRITE_MODE(0), .CLEAR_EN(1),
                      .CLEAR_VAL(8'h00))
    u0 (.i_MCLK(clk), .i_RST(rst0), .bus(if0.slave));

  sram_dp_param_clr #(.AW(8), .DW(8), .RD_LATENCY(1), .WRITE_MODE(1), .CLEAR_EN(0),
                      .CLEAR_VAL(8'h00))
    u1 (.i_MCLK(clk), .i_RST(rst1), .bus(if1.slave));

  sram_dp_param_clr #(.AW(8), .DW(16), .RD_LATENCY(2), .WRITE_MODE(0), .CLEAR_EN(1),
                      .CLEAR_VAL(16'hBEEF))
    u2 (.i_MCLK(clk), .i_RST(rst2), .bus(if2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    if0.addr_a = '0; if0.din_a = '0; if0.wr_a_n = 1'b1; if0.rd_a_n = 1'b1;
    if0.addr_b = '0; if0.rd_b_n = 1'b1;
    if1.addr_a = '0; if1.din_a = '0; if1.wr_a_n = 1'b1; if1.rd_a_n = 1'b1;
    if1.addr_b = '0; if1.rd_b_n = 1'b1;
    if2.addr_a = '0; if2.din_a = '0; if2.wr_a_n = 1'b1; if2.rd_a_n = 1'b1;
    if2.addr_b = '0; if2.rd_b_n = 1'b1;
    v2[0] = 16'h1234; v2[1] = 16'hABCD; v2[2] = 16'h0F0F; v2[3] = 16'h5555;

    // Two clocks of reset on all instances
    tick(); tick();
    chk("rst_busy0",   32'(if0.busy),     32'h1);
    chk("rst_douta0",  32'(if0.dout_a),   32'h0);
    chk("rst_rva0",    32'(if0.rvalid_a), 32'h0);
    chk("rst_doutb0",  32'(if0.dout_b),   32'h0);
    chk("rst_rvb0",    32'(if0.rvalid_b), 32'h0);
    chk("rst_busy1",   32'(if1.busy),     32'h0);
    chk("rst_busy2",   32'(if2.busy),     32'h1);

    // u1: no sweep, write-first; usable right after reset
    rst1 = 1'b0;
    if1.wr_a_n = 1'b0; if1.addr_a = 8'h10; if1.din_a = 8'h11;
    tick();
    chk("u1_busy",     32'(if1.busy), 32'h0);
    if1.din_a = 8'h22; if1.rd_a_n = 1'b0; if1.rd_b_n = 1'b0; if1.addr_b = 8'h10;
    tick();
    chk("wm1_douta",   32'(if1.dout_a),   32'h22);
    chk("wm1_rva",     32'(if1.rvalid_a), 32'h1);
    chk("wm1_doutb",   32'(if1.dout_b),   32'h11);
    chk("wm1_rvb",     32'(if1.rvalid_b), 32'h1);
    if1.wr_a_n = 1'b1; if1.rd_a_n = 1'b1;
    tick();
    chk("wm1_hold",    32'(if1.dout_a),   32'h22);
    chk("wm1_rva_off", 32'(if1.rvalid_a), 32'h0);
    chk("wm1_doutb2",  32'(if1.dout_b),   32'h22);
    if1.rd_b_n = 1'b1;

    // u2: 256-word sweep, then latency-2 back-to-back reads
    rst2 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (if2.busy && n < 1000);
    chk("u2_sweep_len", 32'(n), 32'd256);
    for (int i = 0; i < 4; i++) begin
      if2.wr_a_n = 1'b0; if2.addr_a = 8'(i); if2.din_a = v2[i];
      tick();
    end
    if2.wr_a_n = 1'b0;
    if2.wr_a_n = 1'b1;
    if2.rd_a_n = 1'b0; if2.addr_a = 8'h00;
    tick();
    chk("lat2_first_rva", 32'(if2.rvalid_a), 32'h0);
    for (int i = 1; i < 4; i++) begin
      if2.addr_a = 8'(i);
      tick();
      chk("lat2_rva",  32'(if2.rvalid_a), 32'h1);
      chk("lat2_data", 32'(if2.dout_a),   32'(v2[i-1]));
    end
    if2.rd_a_n = 1'b1;
    tick();
    chk("lat2_rva4",  32'(if2.rvalid_a), 32'h1);
    chk("lat2_data4", 32'(if2.dout_a),   32'(v2[3]));
    tick();
    chk("lat2_rva_off", 32'(if2.rvalid_a), 32'h0);
    chk("lat2_hold",    32'(if2.dout_a),   32'(v2[3]));
    if2.rd_a_n = 1'b0; if2.addr_a = 8'h04; if2.rd_b_n = 1'b0; if2.addr_b = 8'h02;
    tick();
    if2.rd_a_n = 1'b1; if2.rd_b_n = 1'b1;
    chk("lat2_rvb_early", 32'(if2.rvalid_b), 32'h0);
    tick();
    chk("lat2_clrval", 32'(if2.dout_a),   32'hBEEF);
    chk("lat2_rvb",    32'(if2.rvalid_b), 32'h1);
    chk("lat2_doutb",  32'(if2.dout_b),   32'h0F0F);

    // u0: full 4K sweep; port A ignored during it, port B served
    rst0 = 1'b0;
    if0.wr_a_n = 1'b0; if0.addr_a = 12'h005; if0.din_a = 8'h77; if0.rd_a_n = 1'b0;
    n = 0;
    tick(); n++;
    chk("clr_no_rva", 32'(if0.rvalid_a), 32'h0);
    if0.wr_a_n = 1'b1; if0.rd_a_n = 1'b1;
    if0.rd_b_n = 1'b0; if0.addr_b = 12'h000;
    tick(); n++;
    chk("clr_rvb",   32'(if0.rvalid_b), 32'h1);
    chk("clr_doutb", 32'(if0.dout_b),   32'h00);
    if0.rd_b_n = 1'b1;
    while (if0.busy && n < 5000) begin tick(); n++; end
    chk("u0_sweep_len", 32'(n), 32'd4096);

    if0.rd_a_n = 1'b0; if0.addr_a = 12'h000; tick();
    chk("rd000", 32'(if0.dout_a), 32'h00); chk("rd000_rva", 32'(if0.rvalid_a), 32'h1);
    if0.addr_a = 12'h7FF; tick();
    chk("rd7ff", 32'(if0.dout_a), 32'h00); chk("rd7ff_rva", 32'(if0.rvalid_a), 32'h1);
    if0.addr_a = 12'hFFF; tick();
    chk("rdfff", 32'(if0.dout_a), 32'h00); chk("rdfff_rva", 32'(if0.rvalid_a), 32'h1);
    if0.addr_a = 12'h005; tick();
    chk("rd005_ignored_wr", 32'(if0.dout_a), 32'h00);
    if0.rd_a_n = 1'b1; tick();
    chk("rva_off", 32'(if0.rvalid_a), 32'h0);

    if0.wr_a_n = 1'b0; if0.addr_a = 12'h123; if0.din_a = 8'hA5; tick();
    if0.wr_a_n = 1'b1; if0.rd_a_n = 1'b0; tick();
    chk("rd123", 32'(if0.dout_a), 32'hA5); chk("rd123_rva", 32'(if0.rvalid_a), 32'h1);
    if0.rd_a_n = 1'b1; tick();
    chk("rd123_hold", 32'(if0.dout_a), 32'hA5); chk("rd123_rva_off", 32'(if0.rvalid_a), 32'h0);

    if0.wr_a_n = 1'b0; if0.addr_a = 12'h010; if0.din_a = 8'h11; tick();
    if0.din_a = 8'h22; if0.rd_a_n = 1'b0; if0.rd_b_n = 1'b0; if0.addr_b = 12'h010; tick();
    chk("wm0_douta", 32'(if0.dout_a), 32'h11);
    chk("wm0_doutb", 32'(if0.dout_b), 32'h11);
    if0.wr_a_n = 1'b1; if0.rd_b_n = 1'b1; tick();
    chk("wm0_after", 32'(if0.dout_a), 32'h22);
    if0.rd_a_n = 1'b1;
    if0.wr_a_n = 1'b0; if0.addr_a = 12'h900; if0.din_a = 8'h5A; tick();
    if0.wr_a_n = 1'b1;

    // Reset, sweep up to address 0x800, reset again mid-sweep
    rst0 = 1'b1; tick();
    chk("rst2_busy", 32'(if0.busy), 32'h1);
    rst0 = 1'b0;
    for (int i = 0; i < 12'h800; i++) tick();
    chk("mid_busy", 32'(if0.busy), 32'h1);
    rst0 = 1'b1; tick();
    chk("midrst_busy", 32'(if0.busy), 32'h1);
    chk("midrst_rva",  32'(if0.rvalid_a), 32'h0);
    rst0 = 1'b0;
    if0.rd_b_n = 1'b0; if0.addr_b = 12'h900;
    n = 0;
    tick(); n++;
    chk("clr_old_doutb", 32'(if0.dout_b),   32'h5A);
    chk("clr_old_rvb",   32'(if0.rvalid_b), 32'h1);
    if0.rd_b_n = 1'b1;
    while (if0.busy && n < 5000) begin tick(); n++; end
    chk("restart_sweep_len", 32'(n), 32'd4096);
    if0.rd_a_n = 1'b0; if0.addr_a = 12'h900; tick();
    chk("rd900_cleared", 32'(if0.dout_a), 32'h00);
    if0.addr_a = 12'h123; tick();
    chk("rd123_cleared", 32'(if0.dout_a), 32'h00);
    if0.rd_a_n = 1'b1; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
